csr_trap_unit: RTL



---
 rtl/csr_pkg.sv | 46 ++++
 rtl/csr_irq_prio.sv | 30 +++
 rtl/csr_trap_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, interrupt cause codes, mstatus bit positions and the
// read-modify-write helper used by the machine-mode trap unit.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   localparam logic [4:0] IRQ_MTI        = 5'd7;
   localparam logic [4:0] IRQ_MEI        = 5'd11;
   localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   typedef enum logic [1:0] {
      CSR_W   = 2'b00,
      CSR_S   = 2'b01,
      CSR_C   = 2'b10,
      CSR_NOP = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] wdata);
      logic [31:0] res;
      case (op)
         CSR_W:   res = wdata;
         CSR_S:   res = old | wdata;
         CSR_C:   res = old & ~wdata;
         default: res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_irq_prio.sv
// Fixed-priority interrupt selector: MEI > MTI > local lines (lowest index first).
module csr_irq_prio
   import csr_pkg::*;
#(
   parameter int NUM_LIRQ = 4
) (
   input  logic [NUM_LIRQ+15:0] pend,
   output logic                 irq_valid,
   output logic [4:0]           cause
);

   logic [4:0] lirq_cause_s;

   // Pick the winning pending interrupt; only the implemented bits can ever be set.
   always_comb begin
      irq_valid    = |pend;
      lirq_cause_s = 5'd0;
      for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
         lirq_cause_s = pend[16 + i] ? (IRQ_LOCAL_BASE + i[4:0]) : lirq_cause_s;
      end
      if (pend[IRQ_MEI]) begin
         cause = IRQ_MEI;
      end else if (pend[IRQ_MTI]) begin
         cause = IRQ_MTI;
      end else begin
         cause = lirq_cause_s;
      end
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt trap entry, mret and the 64-bit counters
// for the 3-stage core; sits beside execute and redirects fetch on a trap.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int          NUM_LIRQ    = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter bit          CNT_EN      = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [11:0]         csr_addr,
   input  logic [31:0]         csr_wdata,
   input  logic [1:0]          csr_op,
   input  logic                csr_wr,
   input  logic                csr_rd,
   output logic [31:0]         csr_rdata,
   input  logic [31:0]         pc_in,
   input  logic                insn_valid,
   input  logic                insn_retire,
   input  logic                is_mret,
   input  logic                timer_irq,
   input  logic                ext_irq,
   input  logic [NUM_LIRQ-1:0] lirq,
   output logic                trap_taken,
   output logic [31:0]         trap_pc,
   output logic [31:0]         mret_pc
);

   localparam int PEND_W = 16 + NUM_LIRQ;

   logic                mie_bit_r, mpie_r;
   logic                mtie_r, meie_r, mtip_r, meip_r;
   logic [NUM_LIRQ-1:0] lie_r, lip_r;
   logic [31:0]         mepc_r, mcause_r, mtvec_r;
   logic [63:0]         mcycle_r, minstret_r;

   logic [31:0]         mstatus_s, mie_s, mip_s, rd_mux_s, wval_s, base_s;
   logic [PEND_W-1:0]   pend_s;
   logic                irq_valid_s, wr_en_s, mret_s;
   logic [4:0]          cause_s;

   // Assemble architectural views of the packed state bits.
   always_comb begin
      mstatus_s                = MSTATUS_MPP;
      mstatus_s[MSTATUS_MIE]   = mie_bit_r;
      mstatus_s[MSTATUS_MPIE]  = mpie_r;
      mie_s                    = 32'd0;
      mie_s[IRQ_MTI]           = mtie_r;
      mie_s[IRQ_MEI]           = meie_r;
      mie_s[PEND_W-1:16]       = lie_r;
      mip_s                    = 32'd0;
      mip_s[IRQ_MTI]           = mtip_r;
      mip_s[IRQ_MEI]           = meip_r;
      mip_s[PEND_W-1:16]       = lip_r;
   end

   assign pend_s = mip_s[PEND_W-1:0] & mie_s[PEND_W-1:0];

   csr_irq_prio #(.NUM_LIRQ(NUM_LIRQ)) u_prio (
      .pend      (pend_s),
      .irq_valid (irq_valid_s),
      .cause     (cause_s)
   );

   assign trap_taken = mie_bit_r & irq_valid_s & insn_valid;
   assign base_s     = {mtvec_r[31:2], 2'b00};
   assign trap_pc    = (mtvec_r[1:0] == MTVEC_VECTORED) ? (base_s + {25'd0, cause_s, 2'b00}) : base_s;
   assign mret_pc    = mepc_r;
   assign mret_s     = is_mret & insn_valid & ~trap_taken;
   assign wr_en_s    = csr_wr & (csr_op != CSR_NOP);

   // Address decode of the current register values; also the old value for set/clear.
   always_comb begin
      case (csr_addr)
         CSR_MSTATUS:   rd_mux_s = mstatus_s;
         CSR_MIE:       rd_mux_s = mie_s;
         CSR_MTVEC:     rd_mux_s = mtvec_r;
         CSR_MEPC:      rd_mux_s = mepc_r;
         CSR_MCAUSE:    rd_mux_s = mcause_r;
         CSR_MIP:       rd_mux_s = mip_s;
         CSR_MCYCLE:    rd_mux_s = CNT_EN ? mcycle_r[31:0]    : 32'd0;
         CSR_MCYCLEH:   rd_mux_s = CNT_EN ? mcycle_r[63:32]   : 32'd0;
         CSR_MINSTRET:  rd_mux_s = CNT_EN ? minstret_r[31:0]  : 32'd0;
         CSR_MINSTRETH: rd_mux_s = CNT_EN ? minstret_r[63:32] : 32'd0;
         default:       rd_mux_s = 32'd0;
      endcase
   end

   assign csr_rdata = csr_rd ? rd_mux_s : 32'd0;
   assign wval_s    = csr_apply(csr_op_e'(csr_op), rd_mux_s, csr_wdata);

   // Trap entry outranks mret, which outranks a software write to mstatus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie_bit_r <= 1'b0;
         mpie_r    <= 1'b0;
         mepc_r    <= 32'd0;
         mcause_r  <= 32'd0;
      end else if (trap_taken) begin
         mepc_r    <= pc_in;
         mcause_r  <= {1'b1, 26'd0, cause_s};
         mpie_r    <= mie_bit_r;
         mie_bit_r <= 1'b0;
      end else begin
         if (mret_s) begin
            mie_bit_r <= mpie_r;
            mpie_r    <= 1'b1;
         end else if (wr_en_s && csr_addr == CSR_MSTATUS) begin
            mie_bit_r <= wval_s[MSTATUS_MIE];
            mpie_r    <= wval_s[MSTATUS_MPIE];
         end
         if (wr_en_s && csr_addr == CSR_MEPC)   mepc_r   <= {wval_s[31:2], 2'b00};
         if (wr_en_s && csr_addr == CSR_MCAUSE) mcause_r <= wval_s;
      end
   end

   // mtvec/mie software state plus level sampling of the interrupt lines into mip.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtvec_r <= MTVEC_RESET;
         mtie_r  <= 1'b0;
         meie_r  <= 1'b0;
         lie_r   <= '0;
         mtip_r  <= 1'b0;
         meip_r  <= 1'b0;
         lip_r   <= '0;
      end else begin
         mtip_r <= timer_irq;
         meip_r <= ext_irq;
         lip_r  <= lirq;
         if (wr_en_s && csr_addr == CSR_MTVEC) begin
            mtvec_r <= wval_s[1] ? {wval_s[31:2], 2'b00} : wval_s;
         end
         if (wr_en_s && csr_addr == CSR_MIE) begin
            mtie_r <= wval_s[IRQ_MTI];
            meie_r <= wval_s[IRQ_MEI];
            lie_r  <= wval_s[PEND_W-1:16];
         end
      end
   end

   // 64-bit counters; a write to either half replaces that cycle's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcycle_r   <= 64'd0;
         minstret_r <= 64'd0;
      end else if (CNT_EN) begin
         if (wr_en_s && csr_addr == CSR_MCYCLE)       mcycle_r <= {mcycle_r[63:32], wval_s};
         else if (wr_en_s && csr_addr == CSR_MCYCLEH) mcycle_r <= {wval_s, mcycle_r[31:0]};
         else                                         mcycle_r <= mcycle_r + 64'd1;
         if (wr_en_s && csr_addr == CSR_MINSTRET)       minstret_r <= {minstret_r[63:32], wval_s};
         else if (wr_en_s && csr_addr == CSR_MINSTRETH) minstret_r <= {wval_s, minstret_r[31:0]};
         else if (insn_retire)                          minstret_r <= minstret_r + 64'd1;
      end
   end

endmodule
